// File: rtl/mux_n_1_pipe_if.sv
// Handshake bundle between N producer channels, the selector and one consumer.
// master = side driving the inputs and consuming the output; slave = the selector.
interface mux_n_1_pipe_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_n_1_pipe.sv
// N:1 channel selector, fixed-select or round-robin, with one registered output stage.
// Data is picked with a one-hot AND-OR so unselected (possibly X) channels never leak.
module mux_n_1_lane #(
    parameter int WIDTH = 4
) (
    input  logic             gnt,
    input  logic             can_accept,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic [WIDTH-1:0] data_m
);
    assign ready  = gnt & can_accept;
    assign data_m = data & {WIDTH{gnt}};
endmodule

module mux_n_1_pipe #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    mux_n_1_pipe_if.slave    bus
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] chan;
    } out_t;

    out_t                            out_q;
    logic                            out_vld;
    logic                            xfer;
    logic                            can_accept;
    logic [SEL_W-1:0]                rr_ptr;
    logic [SEL_W-1:0]                rr_nxt;
    logic [CHANNELS-1:0]             rot;
    logic                            rr_hit;
    logic [SEL_W-1:0]                rr_off;
    logic [SEL_W:0]                  rr_sum;
    logic [SEL_W-1:0]                rr_idx;
    logic                            fx_hit;
    logic                            gnt_vld;
    logic [SEL_W-1:0]                gnt_idx;
    logic [CHANNELS-1:0]             gnt_oh;
    logic [CHANNELS-1:0]             rdy;
    logic [CHANNELS-1:0][WIDTH-1:0]  data_m;
    logic [WIDTH-1:0]                data_sel;

    assign can_accept = !out_vld || bus.out_ready;

    // Rotate valids so bit 0 is rr_ptr, take the lowest hit, then rotate the offset back.
    always_comb begin
        rot    = CHANNELS'({bus.in_valid, bus.in_valid} >> rr_ptr);
        rr_hit = 1'b0;
        rr_off = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                rr_hit = 1'b1;
                rr_off = SEL_W'(k);
            end
        end
        rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
        if (rr_sum >= (SEL_W+1)'(CHANNELS))
            rr_sum = rr_sum - (SEL_W+1)'(CHANNELS);
        rr_idx = rr_sum[SEL_W-1:0];
    end

    // Out-of-range sel matches no channel, so it can never grant.
    always_comb begin
        fx_hit = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i) && bus.in_valid[i])
                fx_hit = 1'b1;
        end
    end

    assign gnt_vld = mode ? rr_hit : fx_hit;
    assign gnt_idx = mode ? rr_idx : sel;
    assign xfer    = gnt_vld & can_accept;
    assign rr_nxt  = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + SEL_W'(1);

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_lane
            assign gnt_oh[g] = gnt_vld && (gnt_idx == SEL_W'(g));
            mux_n_1_lane #(.WIDTH(WIDTH)) u_lane (
                .gnt        (gnt_oh[g]),
                .can_accept (can_accept),
                .data       (bus.in_data[g*WIDTH +: WIDTH]),
                .ready      (rdy[g]),
                .data_m     (data_m[g])
            );
        end
    endgenerate

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < CHANNELS; i++)
            data_sel = data_sel | data_m[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_q   <= '0;
            rr_ptr  <= '0;
        end else begin
            out_vld <= xfer | (out_vld & ~bus.out_ready);
            if (xfer) begin
                out_q.data <= data_sel;
                out_q.chan <= gnt_idx;
                if (mode)
                    rr_ptr <= rr_nxt;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = out_q.data;
    assign bus.out_chan  = out_q.chan;
    assign bus.out_valid = out_vld;
endmodule
